// File: rtl/mul_rr_arbiter_if.sv
// Bundles the requester-side and multiplier-side signals of the shared-multiplier arbiter.
// The slave modport is the arbiter's view; master is the requesters plus multiplier.
interface mul_rr_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] a_in;
    logic [NREQ*64-1:0] b_in;
    logic               soft_clear;
    logic [NREQ-1:0]    ack;
    logic [127:0]       rsp_result;
    logic               rsp_err;
    logic               busy;
    logic               m_start;
    logic               m_clear;
    logic [63:0]        m_multiplier;
    logic [63:0]        m_multiplicand;
    logic               m_done;
    logic [127:0]       m_result;

    modport slave (
        input  req, a_in, b_in, soft_clear, m_done, m_result,
        output ack, rsp_result, rsp_err, busy, m_start, m_clear, m_multiplier, m_multiplicand
    );

    modport master (
        output req, a_in, b_in, soft_clear, m_done, m_result,
        input  ack, rsp_result, rsp_err, busy, m_start, m_clear, m_multiplier, m_multiplicand
    );
endinterface

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one multi-cycle 64x64 multiplier among NREQ requesters,
// with zero-operand short-circuit, watchdog timeout and soft abort. All outputs registered.
module mul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    mul_rr_arbiter_if.slave bus
);
    localparam int         IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RUN, RESP, CLEAR} state_t;

    state_t           r_state, w_stateNext;
    logic [IDW-1:0]   r_rrPtr, w_rrPtrNext;
    logic [IDW-1:0]   r_grantId, w_grantIdNext;
    logic [7:0]       r_timer, w_timerNext;
    logic [NREQ-1:0]  r_ack, w_ackNext;
    logic [127:0]     r_rspResult, w_rspResultNext;
    logic             r_rspErr, w_rspErrNext;
    logic [63:0]      r_mMult, w_mMultNext;
    logic [63:0]      r_mMcand, w_mMcandNext;
    logic             r_busy, r_mStart, r_mClear;

    logic             w_found;
    logic [IDW-1:0]   w_pick;
    logic [63:0]      w_opA, w_opB;
    logic [7:0]       w_timerInc;

    function automatic logic [IDW-1:0] wrapIdx(input int v);
        return IDW'(v % NREQ);
    endfunction

    // Scan downwards so the requester closest to r_rrPtr is the last (winning) assignment.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_rrPtr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[wrapIdx(int'(r_rrPtr) + k)]) begin
                w_found = 1'b1;
                w_pick  = wrapIdx(int'(r_rrPtr) + k);
            end
        end
    end

    assign w_opA      = bus.a_in[int'(w_pick)*64 +: 64];
    assign w_opB      = bus.b_in[int'(w_pick)*64 +: 64];
    assign w_timerInc = r_timer + 8'd1;

    always_comb begin
        w_stateNext     = r_state;
        w_rrPtrNext     = r_rrPtr;
        w_grantIdNext   = r_grantId;
        w_timerNext     = r_timer;
        w_rspResultNext = r_rspResult;
        w_rspErrNext    = r_rspErr;
        w_mMultNext     = r_mMult;
        w_mMcandNext    = r_mMcand;
        w_ackNext       = '0;

        case (r_state)
            IDLE: begin
                if (!bus.soft_clear && w_found) begin
                    w_grantIdNext = w_pick;
                    w_mMultNext   = w_opA;
                    w_mMcandNext  = w_opB;
                    w_rrPtrNext   = wrapIdx(int'(w_pick) + 1);
                    if (w_opA == 64'd0 || w_opB == 64'd0) begin
                        w_rspResultNext = '0;
                        w_rspErrNext    = 1'b0;
                        w_stateNext     = RESP;
                    end else begin
                        w_stateNext = RUN;
                    end
                end
            end
            RUN: begin
                w_timerNext = w_timerInc;
                if (bus.soft_clear) begin
                    w_stateNext = CLEAR;
                end else if (bus.m_done) begin
                    w_rspResultNext = bus.m_result;
                    w_rspErrNext    = 1'b0;
                    w_stateNext     = RESP;
                end else if (w_timerInc == TMO) begin
                    w_rspResultNext = '0;
                    w_rspErrNext    = 1'b1;
                    w_stateNext     = RESP;
                end
            end
            RESP: begin
                w_stateNext = CLEAR;
            end
            CLEAR: begin
                w_timerNext = '0;
                w_stateNext = bus.soft_clear ? CLEAR : IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        if (w_stateNext == RESP) begin
            w_ackNext[w_grantIdNext] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_rrPtr     <= '0;
            r_grantId   <= '0;
            r_timer     <= '0;
            r_ack       <= '0;
            r_rspResult <= '0;
            r_rspErr    <= 1'b0;
            r_mMult     <= '0;
            r_mMcand    <= '0;
            r_busy      <= 1'b0;
            r_mStart    <= 1'b0;
            r_mClear    <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_rrPtr     <= w_rrPtrNext;
            r_grantId   <= w_grantIdNext;
            r_timer     <= w_timerNext;
            r_ack       <= w_ackNext;
            r_rspResult <= w_rspResultNext;
            r_rspErr    <= w_rspErrNext;
            r_mMult     <= w_mMultNext;
            r_mMcand    <= w_mMcandNext;
            r_busy      <= (w_stateNext != IDLE);
            r_mStart    <= (w_stateNext == RUN);
            r_mClear    <= (w_stateNext == CLEAR);
        end
    end

    assign bus.ack            = r_ack;
    assign bus.rsp_result     = r_rspResult;
    assign bus.rsp_err        = r_rspErr;
    assign bus.busy           = r_busy;
    assign bus.m_start        = r_mStart;
    assign bus.m_clear        = r_mClear;
    assign bus.m_multiplier   = r_mMult;
    assign bus.m_multiplicand = r_mMcand;
endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter: a latency-programmable multiplier model plus a
// transaction-level reference (round-robin winner, product, latency) checked with assertions.
module tb_mul_rr_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 20;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mul_rr_arbiter_if #(.NREQ(NREQ)) bus();

    mul_rr_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Multiplier model: done after mulLat cycles of m_start, held until m_clear.
    int mulLat    = 10;
    bit neverDone = 1'b0;
    int mulCnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.m_done   <= 1'b0;
            bus.m_result <= '0;
            mulCnt       <= 0;
        end else if (bus.m_clear) begin
            bus.m_done <= 1'b0;
            mulCnt     <= 0;
        end else if (bus.m_start && !bus.m_done && !neverDone) begin
            if (mulCnt + 1 >= mulLat) begin
                bus.m_done   <= 1'b1;
                bus.m_result <= {64'b0, bus.m_multiplier} * {64'b0, bus.m_multiplicand};
            end
            mulCnt <= mulCnt + 1;
        end
    end

    int startCycles = 0, clearPulses = 0, ackPulses = 0, multiAck = 0;
    always @(negedge clk) begin
        if (bus.m_start) startCycles++;
        if (bus.m_clear) clearPulses++;
        if (bus.ack != '0) ackPulses++;
        if ($countones(bus.ack) > 1) multiAck++;
    end

    int           rrPtr      = 0;
    logic [127:0] lastResult = '0;
    logic         lastErr    = 1'b0;

    function automatic int pickWinner(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] oneHot(input int id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic sc);
        bus.req        = r;
        bus.soft_clear = sc;
    endtask

    task automatic setOperands(input int id, input logic [63:0] a, input logic [63:0] b);
        bus.a_in[id*64 +: 64] = a;
        bus.b_in[id*64 +: 64] = b;
    endtask

    function automatic logic [63:0] rnd64(input bit allowZero);
        if (allowZero && $urandom_range(0, 3) == 0) return 64'd0;
        return {$urandom, $urandom} | 64'd1;
    endfunction

    // Runs one transaction from an observed-IDLE point and checks it against the reference.
    task automatic runTxn(input int lat, input bit never, input bit scramble);
        logic [NREQ-1:0] rSnap;
        logic [63:0]     ea, eb;
        logic [127:0]    expRes;
        logic            expErr;
        int              expId, expLat, expStarts, s0, c0, n;
        bit              got;
        mulLat    = lat;
        neverDone = never;
        rSnap     = bus.req;
        expId     = pickWinner(rSnap, rrPtr);
        ea        = bus.a_in[expId*64 +: 64];
        eb        = bus.b_in[expId*64 +: 64];
        if (ea == 64'd0 || eb == 64'd0) begin
            expRes = '0; expErr = 1'b0; expLat = 1; expStarts = 0;
        end else if (never || lat + 1 > TMO) begin
            expRes = '0; expErr = 1'b1; expLat = TMO + 1; expStarts = TMO;
        end else begin
            expRes = 128'(ea) * 128'(eb); expErr = 1'b0; expLat = lat + 2; expStarts = lat + 1;
        end
        rrPtr = (expId + 1) % NREQ;
        s0    = startCycles;
        c0    = clearPulses;
        n     = 0;
        got   = 1'b0;
        while (n < 200 && !got) begin
            tick();
            n++;
            if (n == 1) begin
                checkOutput("operand_latch", bus.m_multiplier, ea);
                if (scramble) bus.a_in[expId*64 +: 64] = rnd64(1'b0);
            end
            if (bus.ack != '0) got = 1'b1;
        end
        checkOutput("ack_seen", got, 1);
        checkOutput("ack_id", bus.ack, oneHot(expId));
        checkOutput("latency", n, expLat);
        checkOutput("rsp_result", bus.rsp_result, expRes);
        checkOutput("rsp_err", bus.rsp_err, expErr);
        checkOutput("m_start_cycles", startCycles - s0, expStarts);
        tick();
        checkOutput("ack_one_cycle", bus.ack, 0);
        checkOutput("m_clear_pulse", bus.m_clear, 1);
        tick();
        checkOutput("back_idle", bus.busy, 0);
        checkOutput("clear_count", clearPulses - c0, 1);
        checkOutput("operand_kept", bus.m_multiplicand, eb);
        lastResult = expRes;
        lastErr    = expErr;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int a0, expId;
        applyStimulus('0, 1'b0);
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ack", bus.ack, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_mstart", bus.m_start, 0);
        checkOutput("reset_mclear", bus.m_clear, 0);
        checkOutput("reset_result", bus.rsp_result, 0);
        checkOutput("reset_err", bus.rsp_err, 0);
        checkOutput("reset_mult", bus.m_multiplier, 0);
        reset_n = 1'b1;

        $display("[TB] single request");
        setOperands(0, 64'd5, 64'd7);
        applyStimulus(4'b0001, 1'b0);
        runTxn(10, 1'b0, 1'b0);
        checkOutput("single_35", bus.rsp_result, 128'd35);
        applyStimulus('0, 1'b0);

        $display("[TB] round robin");
        for (int i = 0; i < NREQ; i++) setOperands(i, 64'(i * 1000 + 3), 64'(i * 77 + 11));
        applyStimulus(4'b1111, 1'b0);
        for (int t = 0; t < 5; t++) runTxn($urandom_range(1, 12), 1'b0, 1'b1);
        applyStimulus('0, 1'b0);

        $display("[TB] zero short-circuit");
        setOperands(2, 64'd0, 64'hFFFF);
        applyStimulus(4'b0100, 1'b0);
        runTxn(5, 1'b0, 1'b0);
        applyStimulus('0, 1'b0);

        $display("[TB] timeout then recovery");
        setOperands(1, 64'd123, 64'd456);
        applyStimulus(4'b0010, 1'b0);
        runTxn(5, 1'b1, 1'b0);
        runTxn(6, 1'b0, 1'b0);
        applyStimulus('0, 1'b0);

        $display("[TB] done on the timeout cycle and one cycle late");
        setOperands(3, 64'd9, 64'd9);
        applyStimulus(4'b1000, 1'b0);
        runTxn(TMO - 1, 1'b0, 1'b0);
        runTxn(TMO, 1'b0, 1'b0);
        applyStimulus('0, 1'b0);

        $display("[TB] max product");
        setOperands(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(4'b0001, 1'b0);
        runTxn(8, 1'b0, 1'b0);
        checkOutput("max_product", bus.rsp_result, 128'hFFFFFFFFFFFFFFFE0000000000000001);
        applyStimulus('0, 1'b0);

        $display("[TB] soft clear in RUN");
        setOperands(0, 64'd21, 64'd2);
        setOperands(1, 64'd13, 64'd3);
        applyStimulus(4'b0011, 1'b0);
        mulLat    = 15;
        neverDone = 1'b0;
        expId     = pickWinner(bus.req, rrPtr);
        rrPtr     = (expId + 1) % NREQ;
        a0        = ackPulses;
        tick();
        checkOutput("abort_busy", bus.busy, 1);
        checkOutput("abort_mstart", bus.m_start, 1);
        tick();
        tick();
        applyStimulus(4'b0011, 1'b1);
        tick();
        applyStimulus(4'b0011, 1'b0);
        checkOutput("abort_mclear", bus.m_clear, 1);
        checkOutput("abort_mstart_low", bus.m_start, 0);
        checkOutput("abort_result_kept", bus.rsp_result, lastResult);
        checkOutput("abort_err_kept", bus.rsp_err, lastErr);
        tick();
        checkOutput("abort_idle", bus.busy, 0);
        checkOutput("abort_no_ack", ackPulses - a0, 0);
        runTxn(4, 1'b0, 1'b0);

        $display("[TB] soft clear in IDLE");
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("idle_sc_busy", bus.busy, 0);
        checkOutput("idle_sc_ack", bus.ack, 0);
        applyStimulus(4'b0001, 1'b0);
        runTxn(3, 1'b0, 1'b0);

        $display("[TB] random transactions");
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREQ; i++) setOperands(i, rnd64(1'b1), rnd64(1'b1));
            applyStimulus(4'($urandom_range(1, 15)), 1'b0);
            runTxn($urandom_range(1, TMO + 2), 1'b0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] reset mid-RUN");
        setOperands(1, 64'd1000, 64'd1000);
        applyStimulus(4'b0010, 1'b0);
        runTxn(5, 1'b0, 1'b0);
        setOperands(2, 64'd55, 64'd66);
        applyStimulus(4'b0100, 1'b0);
        mulLat = 12;
        tick();
        tick();
        tick();
        #1 reset_n = 1'b0;
        #1;
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_mstart", bus.m_start, 0);
        checkOutput("rst_result", bus.rsp_result, 0);
        checkOutput("rst_mult", bus.m_multiplier, 0);
        checkOutput("rst_mclear", bus.m_clear, 0);
        rrPtr      = 0;
        lastResult = '0;
        lastErr    = 1'b0;
        for (int i = 0; i < NREQ; i++) setOperands(i, 64'(i + 2), 64'(i + 5));
        applyStimulus(4'b1111, 1'b0);
        #2 reset_n = 1'b1;
        runTxn(4, 1'b0, 1'b0);
        runTxn(4, 1'b0, 1'b0);
        applyStimulus('0, 1'b0);

        checkOutput("ack_onehot", multiAck, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
